axis_pattern_gen: RTL and testbench
===================================

# axis_pattern_gen

Parametrised AXI4-Stream video test-pattern source, the successor to the fixed-size two-pattern sender. It generates frames of configurable resolution and component width, and selects one of four patterns per frame. It honours full TREADY backpressure, reports a frame counter, and can stop cleanly at a frame boundary. It sits at the head of the video pipeline and feeds the downstream AXIS video sink (VDMA, encoder, or HDMI output) in place of a camera or frame buffer.

## Interface
- H_ACTIVE, 640, active pixels per line; multiple of 8, ≥ 8
- V_ACTIVE, 480, active lines per frame; ≥ 1
- COMP_WIDTH, 8, bits per colour component; TDATA width is 3*COMP_WIDTH
- CHECK_LOG2, 5, checkerboard square edge is 2^CHECK_LOG2 pixels; < 16
- AXIS_VID_ACLK  in  1  sole clock; all logic on rising edge
- AXIS_VID_ARESET  in  1  reset, synchronous, active-high
- AXIS_VID_TDATA  out  3*COMP_WIDTH  pixel, packed {R, B, G}, G in LSBs
- AXIS_VID_TLAST  out  1  last pixel of a line (end of line)
- AXIS_VID_TUSER  out  1  first pixel of a frame (start of frame)
- AXIS_VID_TVALID  out  1  beat valid
- AXIS_VID_TREADY  in  1  sink ready
- MODE  in  2  pattern: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 solid COLOR
- COLOR  in  3*COMP_WIDTH  solid colour for MODE 3, same packing as TDATA
- GO  in  1  level; high requests frames
- RUN  out  1  high while a frame is in progress
- FRAME_CNT  out  16  completed frames since reset; wraps 0xFFFF→0

## Operation
- States: IDLE, ACTIVE. Reset forces IDLE, x=y=0, FRAME_CNT=0.
- IDLE→ACTIVE when GO=1. On entry, latch MODE and COLOR and load pixel (0,0).
- Accept means TVALID & TREADY. On each accept, x advances. When x=H_ACTIVE-1, x resets to 0 and y advances.
- The beat with x=H_ACTIVE-1 and y=V_ACTIVE-1 ends the frame. FRAME_CNT increments on its accept.
- At end of frame: if GO=1, stay ACTIVE, relatch MODE/COLOR, and start the next frame with no gap beat. If GO=0, go to IDLE.
- GO falling mid-frame has no effect until the frame ends. MODE/COLOR changes mid-frame are ignored.
- TUSER=1 only at (0,0). TLAST=1 only at x=H_ACTIVE-1.
- Colour bars:
  - Bar index increments every H_ACTIVE/8 pixels, via a counter (no divider).
  - Bars, in order: white, yellow, cyan, green, magenta, red, blue, black.
  - Components are all-ones or zero.
- Grey ramp: R=G=B=x[COMP_WIDTH-1:0], wrapping modulo 2^COMP_WIDTH.
- Checkerboard: white (all ones) if x[CHECK_LOG2]^y[CHECK_LOG2]=0, else black. Bit positions beyond the counter width read as 0.
- Solid: TDATA = latched COLOR.
- x/y counters are $clog2(H_ACTIVE)/$clog2(V_ACTIVE) bits wide, minimum 1.

## Timing
- Reset values: TDATA=0, TLAST=0, TUSER=0, TVALID=0, RUN=0, FRAME_CNT=0.
- All outputs are registered. There is no combinational path from TREADY or GO to any output.
- Start latency: GO=1 sampled in IDLE at edge n; TVALID=1 with pixel (0,0) and TUSER=1 after edge n. RUN rises on the same edge.
- With TREADY=1 continuously, throughput is one pixel per cycle, including across line and frame boundaries.
- While TVALID=1 and TREADY=0, TDATA/TLAST/TUSER hold stable. TVALID is never withdrawn before an accept.
- Stop: last beat accepted at edge m with GO=0, so TVALID=0, RUN=0 after edge m. FRAME_CNT updates at edge m.
- Reset mid-frame: after the reset edge all outputs are at reset values. The partial frame is abandoned, and the next frame starts at (0,0).
- Reset has priority over every other event on the same edge.

## Configuration
- AXIS_PATTERN_SCROLL_EN defined:
  - Ramp and checkerboard use x' = (x + FRAME_CNT) truncated to the x-width in place of x, so the pattern moves one pixel per frame.
  - Bars and solid are unaffected.
- Not defined: all patterns are static, and the adder is absent.

## Test plan
- H_ACTIVE=16, V_ACTIVE=4, MODE=0, TREADY=1, GO held → first beat TUSER=1 and TDATA=0xFFFFFF; bars change every 2 beats (beats 2-3 yellow = {FF,00,FF}); TLAST on beats 15/31/47/63; FRAME_CNT=1 after 64 accepts; beat 64 has TUSER=1 with no gap.
- Same config, TREADY toggling 1,0,1,0 → identical 64-beat data sequence; TDATA/TLAST/TUSER unchanged during every stalled cycle; frame takes 128 cycles.
- GO dropped after beat 10 → beats 11-63 still emitted; TVALID=0 and RUN=0 the cycle after beat 63 is accepted; FRAME_CNT=1.
- MODE 0→2 at beat 20, CHECK_LOG2=1 → rest of frame 0 remains bars; frame 1 pixel (0,0)=white, (2,0)=black, (0,2)=black, (2,2)=white.
- ARESET for one cycle at beat 20 → next cycle TVALID=0, RUN=0, FRAME_CNT=0; GO re-sampled → first beat TUSER=1, pixel (0,0).
- MODE=1 with AXIS_PATTERN_SCROLL_EN → frame 0 pixel (0,0)=0x000000; frame 1 pixel (0,0)=0x010101; without the macro both are 0x000000.

Source files
------------

// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
//   AXI4-Stream video test-pattern source. Emits frames of H_ACTIVE x V_ACTIVE
//   pixels and selects one of four patterns per frame. Honours TREADY
//   backpressure, counts completed frames and stops only at a frame boundary.
//
// Parameters
//   H_ACTIVE    active pixels per line (multiple of 8, >= 8)
//   V_ACTIVE    active lines per frame (>= 1)
//   COMP_WIDTH  bits per colour component; TDATA is 3*COMP_WIDTH, {R,B,G}
//   CHECK_LOG2  checkerboard square edge is 2^CHECK_LOG2 pixels (< 16)
//
// Ports
//   AXIS_VID_ACLK    in   clock, rising edge
//   AXIS_VID_ARESET  in   synchronous active-high reset
//   AXIS_VID_TDATA   out  pixel {R,B,G}
//   AXIS_VID_TLAST   out  end of line
//   AXIS_VID_TUSER   out  start of frame
//   AXIS_VID_TVALID  out  beat valid
//   AXIS_VID_TREADY  in   sink ready
//   MODE             in   0 bars, 1 grey ramp, 2 checkerboard, 3 solid COLOR
//   COLOR            in   solid colour for MODE 3
//   GO               in   level; high requests frames
//   RUN              out  frame in progress
//   FRAME_CNT        out  completed frames since reset (wraps)
//
// Build option
//   AXIS_PATTERN_SCROLL_EN  when defined, ramp and checkerboard use
//                           x + FRAME_CNT so those patterns scroll one pixel
//                           per frame.
// -----------------------------------------------------------------------------
module axis_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COMP_WIDTH = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                    AXIS_VID_ACLK,
  input  logic                    AXIS_VID_ARESET,
  output logic [3*COMP_WIDTH-1:0] AXIS_VID_TDATA,
  output logic                    AXIS_VID_TLAST,
  output logic                    AXIS_VID_TUSER,
  output logic                    AXIS_VID_TVALID,
  input  logic                    AXIS_VID_TREADY,
  input  logic [1:0]              MODE,
  input  logic [3*COMP_WIDTH-1:0] COLOR,
  input  logic                    GO,
  output logic                    RUN,
  output logic [15:0]             FRAME_CNT
);

  localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BARW = H_ACTIVE / 8;
  localparam int BCW  = (BARW > 1) ? $clog2(BARW) : 1;
  localparam int DW   = 3 * COMP_WIDTH;
  // Zero-extended coordinate width, wide enough that any bit the patterns
  // select (component bits, checker bit) exists and reads as 0 past x/y.
  localparam int EW   = XW + YW + COMP_WIDTH + 16;

  localparam logic [XW-1:0]  X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(V_ACTIVE - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(BARW - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_load;      // present a new beat on this edge
  logic            w_restart;   // new beat is pixel (0,0) of a new frame

  logic [XW-1:0]   r_x, w_x_n;
  logic [YW-1:0]   r_y, w_y_n;
  logic [2:0]      r_bar, w_bar_n;
  logic [BCW-1:0]  r_bcnt, w_bcnt_n;
  logic [1:0]      r_mode, w_mode_n;
  logic [DW-1:0]   r_color, w_color_n;
  logic [15:0]     r_fcnt, w_fcnt_n;

  logic [DW-1:0]   r_tdata, w_pix;
  logic            r_tlast, r_tuser, r_tvalid, r_run;

  logic            w_acc, w_eol, w_eof;
  logic [XW-1:0]   w_xs;
  logic [EW-1:0]   w_xe, w_ye;
  logic [COMP_WIDTH-1:0] w_grey;
  logic            w_unused;

  assign w_acc = r_tvalid & AXIS_VID_TREADY;
  assign w_eol = (r_x == X_LAST);
  assign w_eof = w_eol & (r_y == Y_LAST);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge AXIS_VID_ACLK) begin
    if (AXIS_VID_ARESET) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (GO) begin
          w_state_nxt = S_ACTIVE;
          w_load      = 1'b1;
          w_restart   = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (w_acc) begin
          if (w_eof) begin
            // Frame boundary: chain straight into the next frame or stop.
            if (GO) begin
              w_load    = 1'b1;
              w_restart = 1'b1;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------- next beat position
  always_comb begin
    w_x_n    = r_x + 1'b1;
    w_y_n    = r_y;
    w_bar_n  = r_bar;
    w_bcnt_n = r_bcnt + 1'b1;
    if (w_restart || w_eol) begin
      w_x_n    = '0;
      w_bar_n  = '0;
      w_bcnt_n = '0;
      w_y_n    = w_restart ? '0 : r_y + 1'b1;
    end else if (r_bcnt == B_LAST) begin
      // Bar index steps every H_ACTIVE/8 pixels without a divider.
      w_bcnt_n = '0;
      w_bar_n  = r_bar + 1'b1;
    end
  end

  assign w_mode_n  = w_restart ? MODE  : r_mode;
  assign w_color_n = w_restart ? COLOR : r_color;
  // FRAME_CNT as it will read while the new beat is on the bus.
  assign w_fcnt_n  = r_fcnt + {15'd0, (w_acc & w_eof)};

  // ------------------------------------------------------ pixel content
`ifdef AXIS_PATTERN_SCROLL_EN
  logic [XW+15:0] w_sum;
  assign w_sum    = {16'd0, w_x_n} + {{XW{1'b0}}, w_fcnt_n};
  assign w_xs     = w_sum[XW-1:0];
  assign w_unused = ^{w_xe, w_ye, w_sum};
`else
  assign w_xs     = w_x_n;
  assign w_unused = ^{w_xe, w_ye};
`endif

  assign w_xe   = {{(EW-XW){1'b0}}, w_xs};
  assign w_ye   = {{(EW-YW){1'b0}}, w_y_n};
  assign w_grey = w_xe[COMP_WIDTH-1:0];

  always_comb begin
    w_pix = '0;
    case (w_mode_n)
      // white, yellow, cyan, green, magenta, red, blue, black:
      // R on when bar[1]=0, B on when bar[0]=0, G on when bar[2]=0.
      2'd0: w_pix = {{COMP_WIDTH{~w_bar_n[1]}},
                     {COMP_WIDTH{~w_bar_n[0]}},
                     {COMP_WIDTH{~w_bar_n[2]}}};
      2'd1: w_pix = {w_grey, w_grey, w_grey};
      2'd2: w_pix = (w_xe[CHECK_LOG2] ^ w_ye[CHECK_LOG2]) ? '0 : '1;
      default: w_pix = w_color_n;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge AXIS_VID_ACLK) begin
    if (AXIS_VID_ARESET) begin
      r_x      <= '0;
      r_y      <= '0;
      r_bar    <= '0;
      r_bcnt   <= '0;
      r_mode   <= '0;
      r_color  <= '0;
      r_fcnt   <= '0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= 1'b0;
      r_tvalid <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_fcnt   <= w_fcnt_n;
      r_tvalid <= (w_state_nxt == S_ACTIVE);
      r_run    <= (w_state_nxt == S_ACTIVE);
      // Beat registers only move on load, so a stalled beat holds.
      if (w_load) begin
        r_x     <= w_x_n;
        r_y     <= w_y_n;
        r_bar   <= w_bar_n;
        r_bcnt  <= w_bcnt_n;
        r_mode  <= w_mode_n;
        r_color <= w_color_n;
        r_tdata <= w_pix;
        r_tlast <= (w_x_n == X_LAST);
        r_tuser <= w_restart;
      end
    end
  end

  assign AXIS_VID_TDATA  = r_tdata;
  assign AXIS_VID_TLAST  = r_tlast;
  assign AXIS_VID_TUSER  = r_tuser;
  assign AXIS_VID_TVALID = r_tvalid;
  assign RUN             = r_run;
  assign FRAME_CNT       = r_fcnt;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_pattern_gen
//   Directed bench for axis_pattern_gen at 16x4, 8-bit components,
//   2x2 checker squares. Each scenario task drives stimulus and checks
//   its own beats against hand-derived values.
// -----------------------------------------------------------------------------
module tb_axis_pattern_gen;

  logic        clk = 1'b0;
  logic        areset;
  logic [23:0] tdata;
  logic        tlast, tuser, tvalid, tready;
  logic [1:0]  mode;
  logic [23:0] color;
  logic        go, run;
  logic [15:0] fcnt;

  int errors = 0;
  int checks = 0;

  axis_pattern_gen #(
    .H_ACTIVE(16), .V_ACTIVE(4), .COMP_WIDTH(8), .CHECK_LOG2(1)
  ) dut (
    .AXIS_VID_ACLK(clk), .AXIS_VID_ARESET(areset),
    .AXIS_VID_TDATA(tdata), .AXIS_VID_TLAST(tlast), .AXIS_VID_TUSER(tuser),
    .AXIS_VID_TVALID(tvalid), .AXIS_VID_TREADY(tready),
    .MODE(mode), .COLOR(color), .GO(go), .RUN(run), .FRAME_CNT(fcnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected colour bar for column x (bars are 2 pixels wide at H=16).
  function automatic logic [23:0] bar_px(input int x);
    case (x / 2)
      0: return 24'hFFFFFF;  // white
      1: return 24'hFF00FF;  // yellow
      2: return 24'h00FFFF;  // cyan
      3: return 24'h0000FF;  // green
      4: return 24'hFFFF00;  // magenta
      5: return 24'hFF0000;  // red
      6: return 24'h00FF00;  // blue
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    areset = 1'b1; go = 1'b0; tready = 1'b1; mode = 2'd0; color = 24'h0;
    step(); step();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", tvalid); end
    checks++; if (tdata !== 24'h0) begin errors++; $display("FAIL reset_tdata: got %h want 000000", tdata); end
    checks++; if ({tlast, tuser} !== 2'b00) begin errors++; $display("FAIL reset_last_user: got %b want 00", {tlast, tuser}); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL reset_run: got %b want 0", run); end
    checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL reset_fcnt: got %0d want 0", fcnt); end
    step(); step(); step();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL idle_no_go: tvalid %b want 0", tvalid); end
  endtask

  task automatic test_bars();
    do_reset();
    go = 1'b1;
    step();  // GO sampled in IDLE: first beat must be on the bus now
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL start_run: got %b want 1", run); end
    for (int i = 0; i < 64; i++) begin
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL bars_valid beat %0d: got %b want 1", i, tvalid); end
      checks++; if (tdata !== bar_px(i % 16)) begin errors++; $display("FAIL bars_data beat %0d: got %h want %h", i, tdata, bar_px(i % 16)); end
      checks++; if (tlast !== ((i % 16) == 15)) begin errors++; $display("FAIL bars_tlast beat %0d: got %b", i, tlast); end
      checks++; if (tuser !== (i == 0)) begin errors++; $display("FAIL bars_tuser beat %0d: got %b", i, tuser); end
      if (i == 63) begin
        checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL bars_fcnt_mid: got %0d want 0", fcnt); end
      end
      step();
    end
    checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL bars_fcnt: got %0d want 1", fcnt); end
    checks++; if ({tvalid, tuser} !== 2'b11) begin errors++; $display("FAIL bars_next_sof: got %b want 11", {tvalid, tuser}); end
    checks++; if (tdata !== 24'hFFFFFF) begin errors++; $display("FAIL bars_next_data: got %h want ffffff", tdata); end
  endtask

  task automatic test_backpressure();
    int acc, klast;
    logic [25:0] prev;
    do_reset();
    go = 1'b1;
    step();
    acc = 0; klast = -1; prev = '0;
    for (int k = 0; k < 400 && acc < 64; k++) begin
      tready = ((k % 2) == 0);
      if (k > 0 && (k % 2) == 0) begin
        checks++; if ({tdata, tlast, tuser} !== prev) begin errors++; $display("FAIL bp_stable cycle %0d: got %h want %h", k, {tdata, tlast, tuser}, prev); end
      end
      if (tvalid && tready) begin
        checks++; if (tdata !== bar_px(acc % 16)) begin errors++; $display("FAIL bp_data beat %0d: got %h want %h", acc, tdata, bar_px(acc % 16)); end
        checks++; if ({tlast, tuser} !== {((acc % 16) == 15), (acc == 0)}) begin errors++; $display("FAIL bp_flags beat %0d: got %b", acc, {tlast, tuser}); end
        acc++;
        klast = k;
      end
      prev = {tdata, tlast, tuser};
      step();
    end
    tready = 1'b1;
    checks++; if (acc != 64) begin errors++; $display("FAIL bp_accepts: got %0d want 64", acc); end
    checks++; if (klast != 126) begin errors++; $display("FAIL bp_last_cycle: got %0d want 126", klast); end
    checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL bp_fcnt: got %0d want 1", fcnt); end
  endtask

  task automatic test_stop();
    do_reset();
    go = 1'b1;
    step();
    for (int i = 0; i < 64; i++) begin
      checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL stop_valid beat %0d: got %b want 1", i, tvalid); end
      checks++; if (tdata !== bar_px(i % 16)) begin errors++; $display("FAIL stop_data beat %0d: got %h want %h", i, tdata, bar_px(i % 16)); end
      if (i == 40) begin
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL stop_run_mid: got %b want 1", run); end
      end
      if (i == 10) go = 1'b0;
      step();
    end
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stop_tvalid: got %b want 0", tvalid); end
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL stop_run: got %b want 0", run); end
    checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL stop_fcnt: got %0d want 1", fcnt); end
    step(); step();
    checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL stop_stays_idle: got %b want 0", tvalid); end
  endtask

  task automatic test_mode_change();
    do_reset();
    go = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      if (i < 64) begin
        checks++; if (tdata !== bar_px(i % 16)) begin errors++; $display("FAIL mc_bars beat %0d: got %h want %h", i, tdata, bar_px(i % 16)); end
      end
      if (i == 64) begin
        checks++; if ({tuser, tdata} !== {1'b1, 24'hFFFFFF}) begin errors++; $display("FAIL mc_chk_0_0: got %h want 1ffffff", {tuser, tdata}); end
      end
      if (i == 66) begin
        checks++; if (tdata !== 24'h000000) begin errors++; $display("FAIL mc_chk_2_0: got %h want 000000", tdata); end
      end
      if (i == 96) begin
        checks++; if (tdata !== 24'h000000) begin errors++; $display("FAIL mc_chk_0_2: got %h want 000000", tdata); end
      end
      if (i == 98) begin
        checks++; if (tdata !== 24'hFFFFFF) begin errors++; $display("FAIL mc_chk_2_2: got %h want ffffff", tdata); end
      end
      if (i == 20) mode = 2'd2;
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    go = 1'b1;
    mode = 2'd0;
    step();
    for (int i = 0; i < 84; i++) step();
    checks++; if (fcnt !== 16'd1) begin errors++; $display("FAIL rm_fcnt_before: got %0d want 1", fcnt); end
    areset = 1'b1;
    step();
    checks++; if ({tvalid, run} !== 2'b00) begin errors++; $display("FAIL rm_valid_run: got %b want 00", {tvalid, run}); end
    checks++; if (fcnt !== 16'd0) begin errors++; $display("FAIL rm_fcnt: got %0d want 0", fcnt); end
    checks++; if ({tdata, tlast, tuser} !== 26'h0) begin errors++; $display("FAIL rm_beat: got %h want 0", {tdata, tlast, tuser}); end
    areset = 1'b0;
    step();
    checks++; if ({tvalid, tuser} !== 2'b11) begin errors++; $display("FAIL rm_restart_sof: got %b want 11", {tvalid, tuser}); end
    checks++; if (tdata !== 24'hFFFFFF) begin errors++; $display("FAIL rm_restart_data: got %h want ffffff", tdata); end
    step(); step();
    checks++; if ({tuser, tdata} !== {1'b0, 24'hFF00FF}) begin errors++; $display("FAIL rm_x2: got %h want 0ff00ff", {tuser, tdata}); end
  endtask

  task automatic test_ramp();
    logic [23:0] e64, e67;
`ifdef AXIS_PATTERN_SCROLL_EN
    e64 = 24'h010101; e67 = 24'h040404;
`else
    e64 = 24'h000000; e67 = 24'h030303;
`endif
    do_reset();
    mode = 2'd1;
    go = 1'b1;
    step();
    for (int i = 0; i < 68; i++) begin
      if (i == 0) begin
        checks++; if (tdata !== 24'h000000) begin errors++; $display("FAIL ramp_f0_x0: got %h want 000000", tdata); end
      end
      if (i == 5) begin
        checks++; if (tdata !== 24'h050505) begin errors++; $display("FAIL ramp_f0_x5: got %h want 050505", tdata); end
      end
      if (i == 31) begin
        checks++; if (tdata !== 24'h0F0F0F) begin errors++; $display("FAIL ramp_f0_x15: got %h want 0f0f0f", tdata); end
      end
      if (i == 64) begin
        checks++; if (tdata !== e64) begin errors++; $display("FAIL ramp_f1_x0: got %h want %h", tdata, e64); end
      end
      if (i == 67) begin
        checks++; if (tdata !== e67) begin errors++; $display("FAIL ramp_f1_x3: got %h want %h", tdata, e67); end
      end
      step();
    end
  endtask

  task automatic test_solid();
    do_reset();
    mode = 2'd3;
    color = 24'h123456;
    go = 1'b1;
    step();
    for (int i = 0; i < 66; i++) begin
      if (i == 0 || i == 30 || i == 63) begin
        checks++; if (tdata !== 24'h123456) begin errors++; $display("FAIL solid_f0 beat %0d: got %h want 123456", i, tdata); end
      end
      if (i == 64) begin
        checks++; if (tdata !== 24'hABCDEF) begin errors++; $display("FAIL solid_f1: got %h want abcdef", tdata); end
      end
      if (i == 5) color = 24'hABCDEF;
      step();
    end
  endtask

  initial begin
    areset = 1'b1; go = 1'b0; tready = 1'b1; mode = 2'd0; color = 24'h0;
    test_reset();
    test_bars();
    test_backpressure();
    test_stop();
    test_mode_change();
    test_reset_mid();
    test_ramp();
    test_solid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
